// File: rtl/jpegls_pkg.sv
// rtl/jpegls_pkg.sv - shared run-mode constants, state type and default widths
package jpegls_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int CNT_W_DEF = 10;

    localparam logic [1:0] RUN_MODE_IDLE = 2'b00;
    localparam logic [1:0] RUN_MODE_CONT = 2'b10;
    localparam logic [1:0] RUN_MODE_INT  = 2'b11;

    typedef enum logic {
        ST_REG = 1'b0,
        ST_RUN = 1'b1
    } run_state_t;

endpackage

// File: rtl/run_len_counter.sv
// rtl/run_len_counter.sv - run length counter with clear, increment and MAX_RUN compare
module run_len_counter #(
    parameter int CNT_W   = 10,
    parameter int MAX_RUN = 511
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_inc,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_RUN);

    // Length the run would reach if the current pixel matches.
    assign cnt_inc = cnt + 1'b1;
    assign at_max  = (cnt_inc == MAX_V);

    // Count register; clear wins over increment so a chunk emission restarts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/run_mode_ctrl.sv
// rtl/run_mode_ctrl.sv - run/regular mode sequencer with run event and forward outputs
module run_mode_ctrl
    import jpegls_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_RUN = 511
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_x,
    input  logic [PIX_W-1:0] pix_ra,
    input  logic             pix_grad0,
    input  logic             pix_eol,
    output logic             run_en,
    output logic [CNT_W-1:0] run_cnt,
    output logic [1:0]       run_mode,
    output logic             reg_valid,
    input  logic             reg_ready,
    output logic [PIX_W-1:0] reg_x,
    output logic             reg_is_int,
    output logic             in_run
);

    run_state_t       state, state_next;
    logic             accept, run_ctx, match;
    logic             cnt_clr, cnt_inc_en, at_max;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             ev_en, fwd, fwd_int;
    logic [1:0]       ev_mode;
    logic [CNT_W-1:0] ev_cnt;

    // A held forward blocks all pixels, so run events can never overtake it.
    assign pix_ready = ~frame_start & (~reg_valid | reg_ready);
    assign accept    = pix_valid & pix_ready;
    assign run_ctx   = (state == ST_RUN) | pix_grad0;
    assign match     = (pix_x == pix_ra);
    assign in_run    = (state == ST_RUN);

    run_len_counter #(
        .CNT_W   (CNT_W),
        .MAX_RUN (MAX_RUN)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc_en),
        .cnt     (cnt),
        .cnt_inc (cnt_inc),
        .at_max  (at_max)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_REG;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a match stays in RUN unless it ends the line; any mismatch leaves RUN.
    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = ST_REG;
        end else if (accept && run_ctx) begin
            if (match && !pix_eol) begin
                state_next = ST_RUN;
            end else begin
                state_next = ST_REG;
            end
        end
    end

    // Per-pixel decode of run events, forwards and counter control.
    always_comb begin
        ev_en      = 1'b0;
        ev_mode    = RUN_MODE_IDLE;
        ev_cnt     = '0;
        fwd        = 1'b0;
        fwd_int    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc_en = 1'b0;
        if (frame_start) begin
            cnt_clr = 1'b1;
        end else if (accept) begin
            if (!run_ctx) begin
                fwd = 1'b1;
            end else if (match) begin
                if (pix_eol || at_max) begin
                    ev_en   = 1'b1;
                    ev_mode = RUN_MODE_CONT;
                    ev_cnt  = cnt_inc;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc_en = 1'b1;
                end
            end else begin
                ev_en   = 1'b1;
                ev_mode = RUN_MODE_INT;
                ev_cnt  = cnt;
                fwd     = 1'b1;
                fwd_int = 1'b1;
                cnt_clr = 1'b1;
            end
        end
    end

    // Registered event pulse and forward handshake toward the coders.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_en     <= 1'b0;
            run_cnt    <= '0;
            run_mode   <= RUN_MODE_IDLE;
            reg_valid  <= 1'b0;
            reg_x      <= '0;
            reg_is_int <= 1'b0;
        end else begin
            run_en   <= ev_en;
            run_cnt  <= ev_cnt;
            run_mode <= ev_mode;
            if (fwd) begin
                reg_valid  <= 1'b1;
                reg_x      <= pix_x;
                reg_is_int <= fwd_int;
            end else if (reg_ready) begin
                reg_valid <= 1'b0;
            end
        end
    end

endmodule
